// File: rtl/wishbone_single_master_if.sv
// Bundle of the command/response port and the Wishbone master bus for
// wishbone_single_master. The master modport is the bus-initiating side.
`timescale 1ns/1ps
interface wishbone_single_master_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4
) ();
  // command port
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_adr;
  logic [SELECT_WIDTH-1:0] req_sel;
  logic [DATA_WIDTH-1:0]   req_dat;
  // response port
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_dat;
  logic [1:0]              rsp_status;
  // Wishbone bus
  logic                    cyc_o;
  logic                    stb_o;
  logic                    we_o;
  logic [ADDR_WIDTH-1:0]   adr_o;
  logic [SELECT_WIDTH-1:0] sel_o;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic                    ack_i;
  logic                    err_i;
  logic                    rty_i;

  modport master (
    input  req_valid, req_we, req_adr, req_sel, req_dat,
    output req_ready,
    output rsp_valid, rsp_dat, rsp_status,
    output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    output req_valid, req_we, req_adr, req_sel, req_dat,
    input  req_ready,
    input  rsp_valid, rsp_dat, rsp_status,
    input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/wishbone_single_master.sv
// Single-transaction Wishbone classic master. Accepts one command, runs one
// read or write cycle (with bounded retries and a wait-state timeout) and
// returns exactly one response pulse carrying data and a status code.
`timescale 1ns/1ps
module wishbone_single_master #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4,
  parameter int TIMEOUT      = 15,
  parameter int MAX_RETRY    = 3
) (
  input logic                     clk_i,
  input logic                     reset,
  wishbone_single_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_BACKOFF = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_ERR   = 2'd1;
  localparam logic [1:0] ST_RETRY = 2'd2;
  localparam logic [1:0] ST_TMO   = 2'd3;

  localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t                  r_state;
  logic [3:0]              r_retry;
  logic [7:0]              r_tmo;
  logic                    r_live;      // low during reset and until the first edge after release
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [SELECT_WIDTH-1:0] r_sel;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [DATA_WIDTH-1:0]   r_rsp_dat;
  logic [1:0]              r_rsp_status;

  state_t                  w_state_nxt;
  logic [3:0]              w_retry_nxt;
  logic [7:0]              w_tmo_nxt;
  logic [DATA_WIDTH-1:0]   w_rsp_dat_nxt;
  logic [1:0]              w_rsp_status_nxt;
  logic                    w_accept;

  // Next-state, counter and response selection; terminations only matter in BUS.
  always_comb begin
    w_state_nxt      = r_state;
    w_retry_nxt      = r_retry;
    w_tmo_nxt        = r_tmo;
    w_rsp_dat_nxt    = r_rsp_dat;
    w_rsp_status_nxt = r_rsp_status;
    w_accept         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_live && bus.req_valid) begin
          w_accept         = 1'b1;
          w_retry_nxt      = '0;
          w_tmo_nxt        = '0;
          w_rsp_dat_nxt    = '0;
          w_rsp_status_nxt = ST_OK;
          w_state_nxt      = S_BUS;
        end
      end
      S_BUS: begin
        if (bus.err_i) begin
          w_rsp_status_nxt = ST_ERR;
          w_rsp_dat_nxt    = '0;
          w_state_nxt      = S_RESP;
        end else if (bus.rty_i) begin
          if (r_retry == RETRY_LAST) begin
            w_rsp_status_nxt = ST_RETRY;
            w_rsp_dat_nxt    = '0;
            w_state_nxt      = S_RESP;
          end else begin
            w_retry_nxt = r_retry + 4'd1;
            w_tmo_nxt   = '0;
            w_state_nxt = S_BACKOFF;
          end
        end else if (bus.ack_i) begin
          w_rsp_status_nxt = ST_OK;
          w_rsp_dat_nxt    = r_we ? '0 : bus.dat_i;
          w_state_nxt      = S_RESP;
        end else if (r_tmo == TMO_LAST) begin
          w_rsp_status_nxt = ST_TMO;
          w_rsp_dat_nxt    = '0;
          w_state_nxt      = S_RESP;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      S_BACKOFF: w_state_nxt = S_BUS;
      S_RESP:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters and response registers; reset drops any in-flight cycle.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_retry      <= '0;
      r_tmo        <= '0;
      r_live       <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= ST_OK;
    end else begin
      r_state      <= w_state_nxt;
      r_retry      <= w_retry_nxt;
      r_tmo        <= w_tmo_nxt;
      r_live       <= 1'b1;
      r_rsp_dat    <= w_rsp_dat_nxt;
      r_rsp_status <= w_rsp_status_nxt;
    end
  end

  // Command latch: bus address/data stay fixed across wait states and retries.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      r_we  <= 1'b0;
      r_adr <= '0;
      r_sel <= '0;
      r_dat <= '0;
    end else if (w_accept) begin
      r_we  <= bus.req_we;
      r_adr <= bus.req_adr;
      r_sel <= bus.req_sel;
      r_dat <= bus.req_we ? bus.req_dat : '0;
    end
  end

  assign bus.req_ready  = r_live && (r_state == S_IDLE);
  assign bus.cyc_o      = (r_state == S_BUS);
  assign bus.stb_o      = (r_state == S_BUS);
  assign bus.we_o       = r_we;
  assign bus.adr_o      = r_adr;
  assign bus.sel_o      = r_sel;
  assign bus.dat_o      = r_dat;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_dat    = r_rsp_dat;
  assign bus.rsp_status = r_rsp_status;

endmodule

// File: tb/tb_wishbone_single_master.sv
// Directed bench for wishbone_single_master: a scripted slave answers each
// transaction and the observed timing/status is compared to hand values.
`timescale 1ns/1ps
module tb_wishbone_single_master;

  logic clk;
  logic reset;

  wishbone_single_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SELECT_WIDTH(4)) bus ();

  wishbone_single_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT(15), .MAX_RETRY(3)
  ) dut (
    .clk_i (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // results of the last run_txn call
  int          t_stb, t_att, t_lat, t_hold;
  logic [1:0]  t_st;
  logic [31:0] t_rd;
  bit          t_got, t_stable, t_datok, t_rdybad;

  // mode: 0 ack after 'waits' wait states, 1 rty every attempt,
  //       2 ack+err together, 3 never respond
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int mode, input int waits,
                         input logic [31:0] rdata);
    int  wcnt;
    bit  prev_stb;
    t_stb = 0; t_att = 0; t_lat = 0; t_hold = 0; t_st = 2'bxx; t_rd = 'x;
    t_got = 0; t_stable = 1; t_datok = 1; t_rdybad = 0;
    wcnt = 0; prev_stb = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_adr = adr;
    bus.req_sel = sel; bus.req_dat = dat;
    while (!bus.req_ready && t_hold < 20) begin
      @(negedge clk);
      t_hold++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        t_got = 1; t_lat = c; t_st = bus.rsp_status; t_rd = bus.rsp_dat;
        break;
      end
      if (bus.req_ready) t_rdybad = 1;
      if (bus.cyc_o !== bus.stb_o) t_stable = 0;
      bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.rty_i = 1'b0; bus.dat_i = 32'hDEAD_BEEF;
      if (bus.stb_o) begin
        if (!prev_stb) begin
          t_att++;
          wcnt = 0;
        end
        t_stb++;
        if (bus.adr_o !== adr || bus.sel_o !== sel) t_stable = 0;
        if (bus.we_o !== we || bus.dat_o !== (we ? dat : 32'h0)) t_datok = 0;
        case (mode)
          0: if (wcnt == waits) begin bus.ack_i = 1'b1; bus.dat_i = rdata; end
          1: bus.rty_i = 1'b1;
          2: begin bus.ack_i = 1'b1; bus.err_i = 1'b1; bus.dat_i = rdata; end
          default: ;
        endcase
        wcnt++;
      end
      prev_stb = bus.stb_o;
    end
    bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.rty_i = 1'b0;
  endtask

  bit saw_rsp;

  initial begin
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_adr = '0;
    bus.req_sel = '0; bus.req_dat = '0; bus.dat_i = '0;
    bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.rty_i = 1'b0;

    // reset state
    #2;
    chk("rst_cyc",   64'(bus.cyc_o), 64'd0);
    chk("rst_stb",   64'(bus.stb_o), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp",   64'(bus.rsp_valid), 64'd0);
    chk("rst_adr",   64'(bus.adr_o), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk("rel_ready_pre", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1 chk("rel_ready_post", 64'(bus.req_ready), 64'd1);
    @(negedge clk);

    // write, zero-wait ack
    run_txn(1'b1, 32'h4, 4'hF, 32'hA5A5_0F0F, 0, 0, 32'h0);
    chk("wr_hold",   64'(t_hold), 64'd0);
    chk("wr_stb",    64'(t_stb), 64'd1);
    chk("wr_datok",  64'(t_datok), 64'd1);
    chk("wr_lat",    64'(t_lat), 64'd2);
    chk("wr_status", 64'(t_st), 64'd0);
    chk("wr_rdat",   64'(t_rd), 64'd0);
    chk("wr_rdybad", 64'(t_rdybad), 64'd0);
    @(negedge clk);
    chk("wr_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    chk("wr_ready_again", 64'(bus.req_ready), 64'd1);

    // read, 3 wait states
    run_txn(1'b0, 32'h10, 4'h3, 32'hFFFF_FFFF, 0, 3, 32'h1234_5678);
    chk("rd_stb",    64'(t_stb), 64'd4);
    chk("rd_lat",    64'(t_lat), 64'd5);
    chk("rd_rdat",   64'(t_rd), 64'h1234_5678);
    chk("rd_status", 64'(t_st), 64'd0);
    chk("rd_dat_o0", 64'(t_datok), 64'd1);
    chk("rd_stable", 64'(t_stable), 64'd1);
    @(negedge clk);

    // retry on every attempt
    run_txn(1'b0, 32'h0000_0ABC, 4'h1, 32'h0, 1, 0, 32'h0);
    chk("rty_att",    64'(t_att), 64'd4);
    chk("rty_stb",    64'(t_stb), 64'd4);
    chk("rty_lat",    64'(t_lat), 64'd8);
    chk("rty_stable", 64'(t_stable), 64'd1);
    chk("rty_status", 64'(t_st), 64'd2);
    chk("rty_rdat",   64'(t_rd), 64'd0);
    chk("rty_rdybad", 64'(t_rdybad), 64'd0);
    @(negedge clk);

    // ack and err together
    run_txn(1'b0, 32'h20, 4'hF, 32'h0, 2, 0, 32'hCAFE_F00D);
    chk("err_status", 64'(t_st), 64'd1);
    chk("err_rdat",   64'(t_rd), 64'd0);
    chk("err_lat",    64'(t_lat), 64'd2);
    @(negedge clk);

    // timeout, then back-to-back request presented during the RESP cycle
    run_txn(1'b1, 32'h30, 4'hF, 32'h5555_AAAA, 3, 0, 32'h0);
    chk("tmo_stb",    64'(t_stb), 64'd15);
    chk("tmo_lat",    64'(t_lat), 64'd16);
    chk("tmo_status", 64'(t_st), 64'd3);
    run_txn(1'b0, 32'h40, 4'hF, 32'h0, 0, 1, 32'h0BAD_CAFE);
    chk("b2b_hold",   64'(t_hold), 64'd1);
    chk("b2b_stb",    64'(t_stb), 64'd2);
    chk("b2b_status", 64'(t_st), 64'd0);
    chk("b2b_rdat",   64'(t_rd), 64'h0BAD_CAFE);
    @(negedge clk);

    // asynchronous reset in the second wait cycle of a read
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_adr = 32'h50; bus.req_sel = 4'hF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_stb_before", 64'(bus.stb_o), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("ar_cyc",   64'(bus.cyc_o), 64'd0);
    chk("ar_stb",   64'(bus.stb_o), 64'd0);
    chk("ar_ready", 64'(bus.req_ready), 64'd0);
    saw_rsp = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (bus.rsp_valid) saw_rsp = 1;
    end
    @(negedge clk);
    reset = 1'b1;
    #1 chk("ar_ready_pre", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1 chk("ar_ready_post", 64'(bus.req_ready), 64'd1);
    if (bus.rsp_valid) saw_rsp = 1;
    repeat (3) begin
      @(posedge clk);
      #1 if (bus.rsp_valid) saw_rsp = 1;
    end
    chk("ar_no_rsp", 64'(saw_rsp), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
